// File: rtl/slc3_front_panel.sv
// slc3 board front panel: debounced Run/Continue press pulses, synchronized switches,
// and the memory-mapped I/O responder that drives the hex display and LEDs.
module slc3_front_panel #(
  parameter int          DEBOUNCE_CYCLES = 250000,
  parameter logic [15:0] HEX_ADDR        = 16'hFFFF,
  parameter logic [15:0] LED_ADDR        = 16'hFFFE
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Run,
  input  logic        Continue,
  input  logic [15:0] Switches,
  output logic        run_pulse,
  output logic        continue_pulse,
  input  logic [15:0] io_addr,
  input  logic        io_we,
  input  logic [15:0] io_wdata,
  output logic        io_hit,
  output logic [15:0] io_rdata,
  output logic [11:0] LED,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3
);

  localparam int             CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  // Channel 0 is Run, channel 1 is Continue; both are active-low, so 1 means released.
  logic [1:0]    btn_raw;
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    db;
  logic [1:0]    db_q;
  logic [CW-1:0] cnt [2];

  assign btn_raw = {Continue, Run};

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      sync1  <= 2'b11;
      sync2  <= 2'b11;
      db     <= 2'b11;
      db_q   <= 2'b11;
      cnt[0] <= '0;
      cnt[1] <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      db_q  <= db;
      for (int i = 0; i < 2; i++) begin
        // A change is accepted only after it has been seen on every edge of the window.
        if (sync2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          db[i]  <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Pulse on the debounced press edge only (1 -> 0); releases are silent.
  assign run_pulse      = db_q[0] & ~db[0];
  assign continue_pulse = db_q[1] & ~db[1];

  logic [15:0] sw_s1;
  logic [15:0] sw_q;
  logic [15:0] hex_reg;

  // CPU side: io_we is a single-cycle strobe qualified by io_addr; there is no
  // back-pressure, a write lands on the edge where io_we is high and reads are
  // combinational from registered state in the same cycle.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      sw_s1   <= '0;
      sw_q    <= '0;
      hex_reg <= '0;
      LED     <= '0;
    end else begin
      sw_s1 <= Switches;
      sw_q  <= sw_s1;
      if (io_we && io_addr == HEX_ADDR) hex_reg <= io_wdata;
      if (io_we && io_addr == LED_ADDR) LED <= io_wdata[11:0];
    end
  end

  assign io_hit   = (io_addr == HEX_ADDR) || (io_addr == LED_ADDR);
  assign io_rdata = (io_addr == HEX_ADDR) ? sw_q : 16'h0000;

  // Segment order is {g,f,e,d,c,b,a}, active-low.
  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      4'hF:    s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  assign HEX0 = seg7(hex_reg[3:0]);
  assign HEX1 = seg7(hex_reg[7:4]);
  assign HEX2 = seg7(hex_reg[11:8]);
  assign HEX3 = seg7(hex_reg[15:12]);

endmodule
